cmd_ram_ctrl: RTL and testbench

- Command-driven single-clock RAM sitting behind the SPI slave receive path.
- Each received word carries a 2-bit opcode and a payload. The opcode selects one of: set write address, write data, set read address, read data.
- Successor to the fixed 8x256 command RAM. Adds:
  - parametrised data width, address width and depth;
  - optional address auto-increment for bursts;
  - a ready/valid handshake on both the command side and the read-data side;
  - out-of-range address error reporting.

---
 rtl/cmd_ram_pkg.sv | 21 ++
 rtl/cmd_ram_mem.sv | 33 +++
 rtl/cmd_ram_ctrl.sv | 129 ++++++++++++
 tb/tb_cmd_ram_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_ram_pkg.sv
// Shared definitions for the command-driven RAM controller: opcode encoding
// and the address post-increment rule used by both address registers.
package cmd_ram_pkg;

    localparam logic [1:0] OP_SET_WA = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SET_RA = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    // Next address after a data access: wraps to 0 from the last valid word
    // and also from any out-of-range address, so a burst always re-enters the array.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [31:0] depth);
        if (addr >= depth - 32'd1) begin
            return 32'd0;
        end else begin
            return addr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/cmd_ram_mem.sv
// DATA_W x DEPTH storage array: one synchronous write port and one registered
// read port. Contents and read register are intentionally not reset.
module cmd_ram_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port; callers only assert we for in-range addresses.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/cmd_ram_ctrl.sv
// Command-driven RAM controller behind the SPI receive path: opcode decode,
// write/read address registers, ready/valid handshakes and range-error pulse.
module cmd_ram_ctrl
    import cmd_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              err
);

    localparam logic [31:0] DEPTH_W32 = 32'(DEPTH);

    logic [1:0]        op_s;
    logic [DATA_W-1:0] payload_s;
    logic              accept_s;
    logic              set_wa_s;
    logic              do_wr_s;
    logic              set_ra_s;
    logic              do_rd_s;
    logic              wr_ok_s;
    logic              rd_ok_s;
    logic [ADDR_W-1:0] wr_next_s;
    logic [ADDR_W-1:0] rd_next_s;
    logic [DATA_W-1:0] rdata_s;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              tx_valid_r;
    logic              zero_r;
    logic              err_r;

    assign op_s      = din[DATA_W+1:DATA_W];
    assign payload_s = din[DATA_W-1:0];

    // Every command stalls while unconsumed read data is sitting on dout.
    assign rx_ready  = !(tx_valid_r && !tx_ready);
    assign accept_s  = rx_valid && rx_ready;

    assign wr_ok_s   = (32'(wr_addr_r) < DEPTH_W32);
    assign rd_ok_s   = (32'(rd_addr_r) < DEPTH_W32);
    assign wr_next_s = ADDR_W'(next_addr(32'(wr_addr_r), DEPTH_W32));
    assign rd_next_s = ADDR_W'(next_addr(32'(rd_addr_r), DEPTH_W32));

    // Opcode decode, qualified by acceptance.
    always_comb begin
        set_wa_s = 1'b0;
        do_wr_s  = 1'b0;
        set_ra_s = 1'b0;
        do_rd_s  = 1'b0;
        if (accept_s) begin
            case (op_s)
                OP_SET_WA: set_wa_s = 1'b1;
                OP_WRITE:  do_wr_s  = 1'b1;
                OP_SET_RA: set_ra_s = 1'b1;
                OP_READ:   do_rd_s  = 1'b1;
                default:   set_wa_s = 1'b0;
            endcase
        end else begin
            set_wa_s = 1'b0;
        end
    end

    // Write and read address registers with optional post-increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_addr_r <= {ADDR_W{1'b0}};
            rd_addr_r <= {ADDR_W{1'b0}};
        end else begin
            if (set_wa_s) begin
                wr_addr_r <= payload_s[ADDR_W-1:0];
            end else if (do_wr_s && AUTO_INC) begin
                wr_addr_r <= wr_next_s;
            end
            if (set_ra_s) begin
                rd_addr_r <= payload_s[ADDR_W-1:0];
            end else if (do_rd_s && AUTO_INC) begin
                rd_addr_r <= rd_next_s;
            end
        end
    end

    // Read-data valid, zero-forcing for out-of-range reads, and the error pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_valid_r <= 1'b0;
            zero_r     <= 1'b1;
            err_r      <= 1'b0;
        end else begin
            err_r <= (do_wr_s && !wr_ok_s) || (do_rd_s && !rd_ok_s);
            if (do_rd_s) begin
                tx_valid_r <= 1'b1;
                zero_r     <= !rd_ok_s;
            end else if (tx_ready) begin
                tx_valid_r <= 1'b0;
            end
        end
    end

    // The array's read register is not reset, so zero_r masks it after reset
    // and after an out-of-range read; both sources are registers.
    assign dout     = zero_r ? {DATA_W{1'b0}} : rdata_s;
    assign tx_valid = tx_valid_r;
    assign err      = err_r;

    cmd_ram_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (do_wr_s && wr_ok_s),
        .waddr (wr_addr_r),
        .wdata (payload_s),
        .re    (do_rd_s && rd_ok_s),
        .raddr (rd_addr_r),
        .rdata (rdata_s)
    );

endmodule

// File: tb/tb_cmd_ram_ctrl.sv
// Directed bench for cmd_ram_ctrl: three instances cover the default build,
// DEPTH=200 (range errors) and AUTO_INC=0 (held addresses).
module tb_cmd_ram_ctrl;
    import cmd_ram_pkg::*;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [9:0] din      [3];
    logic       rx_valid [3];
    logic       rx_ready [3];
    logic [7:0] dout     [3];
    logic       tx_valid [3];
    logic       tx_ready [3];
    logic       err      [3];
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cmd_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .AUTO_INC(1'b1)) u_dut0 (
        .clk(clk), .rstn(rstn), .din(din[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
        .dout(dout[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .err(err[0]));
    cmd_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .AUTO_INC(1'b1)) u_dut1 (
        .clk(clk), .rstn(rstn), .din(din[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
        .dout(dout[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .err(err[1]));
    cmd_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .AUTO_INC(1'b0)) u_dut2 (
        .clk(clk), .rstn(rstn), .din(din[2]), .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]),
        .dout(dout[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .err(err[2]));

    // Present one command to instance d and hold it until the accepting edge.
    task automatic cmd(input int d, input logic [1:0] op, input logic [7:0] pl);
        int n;
        n = 0;
        din[d]      = {op, pl};
        rx_valid[d] = 1'b1;
        while (!rx_ready[d] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (rx_ready[d] !== 1'b1) begin
            $display("FAIL cmd_accept dut%0d: rx_ready=%b required 1 (timeout)", d, rx_ready[d]);
            miscompares++;
        end
        @(posedge clk); #1;
        rx_valid[d] = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (dout[d] !== 8'h00 || tx_valid[d] !== 1'b0 || err[d] !== 1'b0 || rx_ready[d] !== 1'b1) begin
                $display("FAIL reset dut%0d: dout=%h tx_valid=%b err=%b rx_ready=%b required 00 0 0 1",
                         d, dout[d], tx_valid[d], err[d], rx_ready[d]);
                miscompares++;
            end
        end
    endtask

    task automatic test_basic();
        cmd(0, OP_SET_WA, 8'h10);
        cmd(0, OP_WRITE,  8'hA5);
        cmd(0, OP_SET_RA, 8'h10);
        cmd(0, OP_READ,   8'h00);
        vectors++;
        if (dout[0] !== 8'hA5 || tx_valid[0] !== 1'b1 || err[0] !== 1'b0) begin
            $display("FAIL basic_read: dout=%h tx_valid=%b err=%b required a5 1 0", dout[0], tx_valid[0], err[0]);
            miscompares++;
        end
        idle();
        vectors++;
        if (dout[0] !== 8'hA5 || tx_valid[0] !== 1'b0) begin
            $display("FAIL basic_consume: dout=%h tx_valid=%b required a5 0", dout[0], tx_valid[0]);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_data [3];
        exp_data[0] = 8'h11;
        exp_data[1] = 8'h22;
        exp_data[2] = 8'h33;
        cmd(0, OP_SET_WA, 8'hFE);
        for (int i = 0; i < 3; i++) cmd(0, OP_WRITE, exp_data[i]);
        cmd(0, OP_SET_RA, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            cmd(0, OP_READ, 8'h00);
            vectors++;
            if (dout[0] !== exp_data[i] || tx_valid[0] !== 1'b1 || err[0] !== 1'b0) begin
                $display("FAIL burst_read[%0d]: dout=%h tx_valid=%b err=%b required %h 1 0",
                         i, dout[0], tx_valid[0], err[0], exp_data[i]);
                miscompares++;
            end
        end
        idle();
        vectors++;
        if (tx_valid[0] !== 1'b0) begin
            $display("FAIL burst_end: tx_valid=%b required 0", tx_valid[0]);
            miscompares++;
        end
    endtask

    task automatic test_stall();
        cmd(0, OP_SET_WA, 8'h41);
        cmd(0, OP_WRITE,  8'h12);
        cmd(0, OP_SET_WA, 8'h40);
        cmd(0, OP_SET_RA, 8'h10);
        tx_ready[0] = 1'b0;
        cmd(0, OP_READ, 8'h00);
        din[0]      = {OP_WRITE, 8'h99};
        rx_valid[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (rx_ready[0] !== 1'b0) begin
                $display("FAIL stall_rx_ready[%0d]: rx_ready=%b required 0", i, rx_ready[0]);
                miscompares++;
            end
            idle();
            vectors++;
            if (dout[0] !== 8'hA5 || tx_valid[0] !== 1'b1) begin
                $display("FAIL stall_hold[%0d]: dout=%h tx_valid=%b required a5 1", i, dout[0], tx_valid[0]);
                miscompares++;
            end
        end
        tx_ready[0] = 1'b1;
        #1;
        vectors++;
        if (rx_ready[0] !== 1'b1) begin
            $display("FAIL stall_release: rx_ready=%b required 1", rx_ready[0]);
            miscompares++;
        end
        idle();
        rx_valid[0] = 1'b0;
        vectors++;
        if (tx_valid[0] !== 1'b0) begin
            $display("FAIL stall_drain: tx_valid=%b required 0", tx_valid[0]);
            miscompares++;
        end
        cmd(0, OP_SET_RA, 8'h40);
        cmd(0, OP_READ, 8'h00);
        vectors++;
        if (dout[0] !== 8'h99) begin
            $display("FAIL stall_write_applied: dout=%h required 99", dout[0]);
            miscompares++;
        end
        cmd(0, OP_READ, 8'h00);
        vectors++;
        if (dout[0] !== 8'h12) begin
            $display("FAIL stall_write_once: dout=%h required 12", dout[0]);
            miscompares++;
        end
        idle();
    endtask

    task automatic test_out_of_range();
        cmd(1, OP_SET_WA, 8'hC7);
        cmd(1, OP_WRITE,  8'h77);
        vectors++;
        if (err[1] !== 1'b0) begin
            $display("FAIL oob_inrange_write: err=%b required 0", err[1]);
            miscompares++;
        end
        cmd(1, OP_SET_WA, 8'hC8);
        cmd(1, OP_WRITE,  8'h55);
        vectors++;
        if (err[1] !== 1'b1) begin
            $display("FAIL oob_write_err: err=%b required 1", err[1]);
            miscompares++;
        end
        idle();
        vectors++;
        if (err[1] !== 1'b0) begin
            $display("FAIL oob_write_pulse: err=%b required 0", err[1]);
            miscompares++;
        end
        cmd(1, OP_WRITE,  8'hAB);
        cmd(1, OP_SET_RA, 8'hC7);
        cmd(1, OP_READ,   8'h00);
        vectors++;
        if (dout[1] !== 8'h77 || err[1] !== 1'b0) begin
            $display("FAIL oob_last_word: dout=%h err=%b required 77 0", dout[1], err[1]);
            miscompares++;
        end
        cmd(1, OP_SET_RA, 8'h00);
        cmd(1, OP_READ,   8'h00);
        vectors++;
        if (dout[1] !== 8'hAB) begin
            $display("FAIL oob_write_wrap: dout=%h required ab", dout[1]);
            miscompares++;
        end
        cmd(1, OP_SET_RA, 8'hC8);
        cmd(1, OP_READ,   8'h00);
        vectors++;
        if (dout[1] !== 8'h00 || tx_valid[1] !== 1'b1 || err[1] !== 1'b1) begin
            $display("FAIL oob_read: dout=%h tx_valid=%b err=%b required 00 1 1", dout[1], tx_valid[1], err[1]);
            miscompares++;
        end
        idle();
        vectors++;
        if (err[1] !== 1'b0 || tx_valid[1] !== 1'b0 || dout[1] !== 8'h00) begin
            $display("FAIL oob_read_pulse: err=%b tx_valid=%b dout=%h required 0 0 00", err[1], tx_valid[1], dout[1]);
            miscompares++;
        end
    endtask

    task automatic test_no_inc();
        cmd(2, OP_SET_WA, 8'h05);
        cmd(2, OP_WRITE,  8'h3C);
        cmd(2, OP_SET_RA, 8'h05);
        for (int i = 0; i < 2; i++) begin
            cmd(2, OP_READ, 8'h00);
            vectors++;
            if (dout[2] !== 8'h3C || tx_valid[2] !== 1'b1) begin
                $display("FAIL noinc_read[%0d]: dout=%h tx_valid=%b required 3c 1", i, dout[2], tx_valid[2]);
                miscompares++;
            end
        end
        cmd(2, OP_SET_WA, 8'h05);
        cmd(2, OP_WRITE,  8'h7E);
        cmd(2, OP_READ,   8'h00);
        vectors++;
        if (dout[2] !== 8'h7E) begin
            $display("FAIL noinc_write_then_read: dout=%h required 7e", dout[2]);
            miscompares++;
        end
        cmd(2, OP_WRITE, 8'h5A);
        cmd(2, OP_READ,  8'h00);
        vectors++;
        if (dout[2] !== 8'h5A) begin
            $display("FAIL noinc_addr_hold: dout=%h required 5a", dout[2]);
            miscompares++;
        end
        idle();
    endtask

    task automatic test_reset_mid_burst();
        cmd(0, OP_SET_RA, 8'h10);
        tx_ready[0] = 1'b0;
        cmd(0, OP_READ, 8'h00);
        #2;
        rstn = 1'b0;
        #1;
        vectors++;
        if (tx_valid[0] !== 1'b0 || dout[0] !== 8'h00 || rx_ready[0] !== 1'b1) begin
            $display("FAIL reset_mid_burst: tx_valid=%b dout=%h rx_ready=%b required 0 00 1",
                     tx_valid[0], dout[0], rx_ready[0]);
            miscompares++;
        end
        @(negedge clk);
        rstn        = 1'b1;
        tx_ready[0] = 1'b1;
        idle();
        cmd(0, OP_READ, 8'h00);
        vectors++;
        if (dout[0] !== 8'h33 || tx_valid[0] !== 1'b1) begin
            $display("FAIL reset_rd_addr: dout=%h tx_valid=%b required 33 1", dout[0], tx_valid[0]);
            miscompares++;
        end
        cmd(0, OP_WRITE,  8'h44);
        cmd(0, OP_SET_RA, 8'h00);
        cmd(0, OP_READ,   8'h00);
        vectors++;
        if (dout[0] !== 8'h44) begin
            $display("FAIL reset_wr_addr: dout=%h required 44", dout[0]);
            miscompares++;
        end
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            din[d]      = 10'h000;
            rx_valid[d] = 1'b0;
            tx_ready[d] = 1'b1;
        end
        #12;
        test_reset();
        #5;
        rstn = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_back_to_back();
        test_stall();
        test_out_of_range();
        test_no_inc();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
